// File: rtl/mult_div_engine.sv
// ----------------------------------------------------------------------------
// mult_div_engine
//
// Multi-cycle multiply/divide unit for the E-stage HI/LO datapath.
// It computes the result in the launch cycle and parks it in res_hi/res_lo.
// A down-counter then holds the unit busy for a fixed latency before the
// parked result is committed to the architectural HI/LO registers. This gives
// the downstream hazard logic the timing of a real iterative unit.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..255)
//   DIV_CYCLES   busy cycles for div/divu   (1..255)
//
// Optional feature:
//   MULT_DIV_MADD_EN  when defined, acc=1 on a mult/multu launch accumulates
//                     the product into {hi,lo} instead of overwriting it.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   A       in   32-bit multiplicand / dividend
//   B       in   32-bit multiplier / divisor
//   ctrl    in   00 mult, 01 multu, 10 div, 11 divu
//   start   in   launch request (A, B, ctrl, acc valid in the same cycle)
//   acc     in   accumulate request (only with MULT_DIV_MADD_EN)
//   hi_we   in   mthi write enable (idle only)
//   lo_we   in   mtlo write enable (idle only)
//   wdata   in   32-bit mthi/mtlo data
//   hi      out  architectural HI
//   lo      out  architectural LO
//   busy    out  an operation is in flight
// ----------------------------------------------------------------------------
module mult_div_engine #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ctrl,
    input  logic        start,
    input  logic        acc,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter reload values: the counter runs from latency-1 down to 0.
    localparam logic [7:0] MULT_LAST = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LAST  = 8'(DIV_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_valid;
    logic        launch;
    logic        commit;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [63:0] op_result;

`ifdef MULT_DIV_MADD_EN
    logic        res_acc;
`else
    logic        unused_acc;
    assign unused_acc = acc;
`endif

    assign launch = (state == IDLE) && start;
    assign commit = (state == RUN) && (cnt == 8'd0);
    assign busy   = (state == RUN);

    // Signed and unsigned 64-bit products are both formed from explicitly
    // widened operands, so the upper word is exact for either flavour.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The divide-by-zero case is substituted with a divisor of 1 so the
    // dividers never see zero. That result is discarded through res_valid.
    // The single signed overflow case (-2^31 / -1) is pinned to the
    // wrapped quotient with a zero remainder.
    always_comb begin
        div_b  = (B == 32'd0) ? 32'd1 : B;
        quot_u = A / div_b;
        rem_u  = A % div_b;
        if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(A) / $signed(div_b);
            rem_s  = $signed(A) % $signed(div_b);
        end
    end

    // Select the {hi,lo} pair for the requested operation.
    always_comb begin
        op_result = 64'd0;
        case (ctrl)
            2'b00:   op_result = prod_s;
            2'b01:   op_result = prod_u;
            2'b10:   op_result = {rem_s, quot_s};
            default: op_result = {rem_u, quot_u};
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A start request that arrives while RUN is ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (cnt == 8'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latency counter and parked result. The result is captured at launch.
    // A reset during RUN clears res_valid, which drops the in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 8'd0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            res_valid <= 1'b0;
`ifdef MULT_DIV_MADD_EN
            res_acc   <= 1'b0;
`endif
        end else if (launch) begin
            cnt       <= ctrl[1] ? DIV_LAST : MULT_LAST;
            res_hi    <= op_result[63:32];
            res_lo    <= op_result[31:0];
            res_valid <= !(ctrl[1] && (B == 32'd0));
`ifdef MULT_DIV_MADD_EN
            res_acc   <= acc && !ctrl[1];
`endif
        end else if (state == RUN) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Architectural HI/LO. A commit of a valid result takes effect at the
    // end of RUN. mthi/mtlo writes land only when the unit is idle and no
    // launch is happening in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (res_valid) begin
`ifdef MULT_DIV_MADD_EN
                if (res_acc) begin
                    {hi, lo} <= {hi, lo} + {res_hi, res_lo};
                end else begin
                    {hi, lo} <= {res_hi, res_lo};
                end
`else
                {hi, lo} <= {res_hi, res_lo};
`endif
            end
        end else if ((state == IDLE) && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_mult_div_engine.sv
// ----------------------------------------------------------------------------
// tb_mult_div_engine
//
// Scoreboard bench for mult_div_engine. Each launch computes the expected
// {hi,lo} from an independent sign/magnitude model and queues it. The entry
// is popped and compared once busy drops. The bench also tracks the
// architectural HI/LO it expects in model_hi/model_lo.
// ----------------------------------------------------------------------------
module tb_mult_div_engine;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ctrl;
    logic        start;
    logic        acc;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          checks;
    int          failures;

    mult_div_engine #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .ctrl  (ctrl),
        .start (start),
        .acc   (acc),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result built from sign/magnitude arithmetic.
    function automatic logic [63:0] modelResult(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic acc_in,
                                                input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        p = 64'd0;
        case (op)
            2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {cur_hi, cur_lo};
                ma = a[31] ? (~a + 32'd1) : a;
                mb = b[31] ? (~b + 32'd1) : b;
                q  = ma / mb;
                r  = ma % mb;
                if (a[31] != b[31]) q = ~q + 32'd1;
                if (a[31]) r = ~r + 32'd1;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {cur_hi, cur_lo};
                return {a % b, a / b};
            end
        endcase
`ifdef MULT_DIV_MADD_EN
        if (acc_in) p = p + {cur_hi, cur_lo};
`else
        if (acc_in) p = p + 64'd0;
`endif
        return p;
    endfunction

    // mthi/mtlo from idle; the write must appear after one edge.
    task automatic writeHiLo(input logic hwe, input logic lwe, input logic [31:0] data);
        hi_we = hwe;
        lo_we = lwe;
        wdata = data;
        @(posedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hwe) model_hi = data;
        if (lwe) model_lo = data;
        checkOutput("mt_hi", {32'd0, hi}, {32'd0, model_hi});
        checkOutput("mt_lo", {32'd0, lo}, {32'd0, model_lo});
    endtask

    // Launch one operation and follow it through busy to commit.
    // poke: attempt a start and an mtlo on the second busy cycle.
    // collide: raise hi_we together with start in the launch cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic acc_in, input logic poke, input logic collide,
                                 input int n);
        logic [63:0] exp_v;
        int cyc;
        exp_v = modelResult(op, a, b, acc_in, model_hi, model_lo);
        exp_q.push_back(exp_v);
        ctrl  = op;
        A     = a;
        B     = b;
        acc   = acc_in;
        start = 1'b1;
        if (collide) begin
            hi_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        start = 1'b0;
        acc   = 1'b0;
        hi_we = 1'b0;
        cyc   = 0;
        while (busy && cyc < 300) begin
            if (cyc == 2) begin
                checkOutput("hold_hi", {32'd0, hi}, {32'd0, model_hi});
                checkOutput("hold_lo", {32'd0, lo}, {32'd0, model_lo});
            end
            if (poke && cyc == 1) begin
                start = 1'b1;
                ctrl  = 2'b11;
                A     = 32'd1;
                B     = 32'd1;
                lo_we = 1'b1;
                wdata = 32'h0BAD_0BAD;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lo_we = 1'b0;
            cyc++;
        end
        checkOutput("busy_cycles", 64'(cyc), 64'(n));
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checkOutput("res_hi", {32'd0, hi}, {32'd0, exp_v[63:32]});
            checkOutput("res_lo", {32'd0, lo}, {32'd0, exp_v[31:0]});
            model_hi = exp_v[63:32];
            model_lo = exp_v[31:0];
        end
    endtask

    // Main sequence.
    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        checks   = 0;
        failures = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset = 1'b1;
        A     = 32'd0;
        B     = 32'd0;
        ctrl  = 2'b00;
        start = 1'b0;
        acc   = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_hi", {32'd0, hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0, MULT_N);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, MULT_N);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, DIV_N);
        applyStimulus(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, DIV_N);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, DIV_N);
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, DIV_N);

        writeHiLo(1'b1, 1'b0, 32'h1234_5678);
        applyStimulus(2'b00, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, MULT_N);
        applyStimulus(2'b01, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0, 1'b1, MULT_N);
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, DIV_N);

        writeHiLo(1'b1, 1'b1, 32'hCAFE_F00D);
        writeHiLo(1'b1, 1'b0, 32'd0);
        writeHiLo(1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(2'b01, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, MULT_N);
        applyStimulus(2'b10, 32'd9, 32'd4, 1'b1, 1'b0, 1'b0, DIV_N);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            applyStimulus(rop, ra, rb, 1'b0, 1'b0, 1'b0, rop[1] ? DIV_N : MULT_N);
        end

        // Reset on the third busy cycle of a divide aborts the result.
        writeHiLo(1'b1, 1'b1, 32'd5);
        ctrl  = 2'b10;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_hi", {32'd0, hi}, 64'd0);
        checkOutput("abort_lo", {32'd0, lo}, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("late_busy", {63'd0, busy}, 64'd0);
        checkOutput("late_hi", {32'd0, hi}, 64'd0);
        checkOutput("late_lo", {32'd0, lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_engine.md
# mult_div_engine

Multi-cycle multiply/divide execution unit for the E-stage HI/LO datapath. Consumes the cached operands, operation code and start pulse produced by the operand-caching source stage directly upstream, runs a fixed-latency signed/unsigned multiply or divide, and commits the result to architectural HI/LO registers. Exposes `busy` so hazard logic can stall subsequent mult/div/mfhi/mflo/mthi/mtlo instructions, and accepts direct mthi/mtlo writes when idle.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (legal range 1..255)
- `DIV_CYCLES`, 10, busy cycles for div/divu (legal range 1..255)

- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `A`  in  32  operand A (multiplicand / dividend)
- `B`  in  32  operand B (multiplier / divisor)
- `ctrl`  in  2  00 mult, 01 multu, 10 div, 11 divu
- `start`  in  1  launch request; A, B, ctrl, acc valid in the same cycle
- `acc`  in  1  accumulate request (used only with `MULT_DIV_MADD_EN`)
- `hi_we`  in  1  mthi write enable
- `lo_we`  in  1  mtlo write enable
- `wdata`  in  32  mthi/mtlo data
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `busy`  out  1  operation in flight

## Operation
- States: IDLE, RUN. 8-bit down-counter `cnt`; latched op/result registers `res_hi`, `res_lo`, `res_valid`.
- IDLE, `start`=1: latch result of A,B,ctrl into `res_*`; `cnt` <= latency-1 (MULT_CYCLES or DIV_CYCLES); go RUN.
- RUN: `cnt` decrements each edge; at edge with `cnt`==0 commit `res_hi`/`res_lo` to hi/lo (if `res_valid`), go IDLE.
- mult: {hi,lo} = signed 32x32 -> 64 product. multu: unsigned product.
- div: lo = quotient truncated toward zero, hi = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0, ctrl 1x): `res_valid`=0; full DIV_CYCLES still elapse; hi/lo unchanged.
- `start` while RUN: ignored (upstream guarantees stall; no queueing).
- `hi_we`/`lo_we` in IDLE without `start`: hi/lo <= wdata next edge; both may fire together. Ignored while RUN. If `start` and a write coincide in IDLE, `start` wins, write dropped.
- `busy` = (state == RUN), registered.

## Timing
- Reset: state IDLE, `busy`=0, hi=0, lo=0, `cnt`=0, `res_valid`=0. Reset during RUN aborts; in-flight result never committed.
- `start` sampled at edge E0. `busy`=1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES); new hi/lo visible and `busy`=0 in the cycle after the last busy cycle (edge E0+N).
- Back-to-back: `start` accepted in the first cycle `busy`=0; re-launch with zero idle gap allowed.
- mthi/mtlo latency: 1 edge.
- hi/lo hold their old value throughout RUN.

## Configuration
- `MULT_DIV_MADD_EN` defined: `acc`=1 with ctrl 00/01 at launch makes commit {hi,lo} <= {hi,lo} + product (64-bit, wrap mod 2^64; signed product sign-extended for mult). `acc` ignored with div ctrl.
- Not defined: `acc` port present but ignored; commit always overwrites {hi,lo}.

## Test plan
- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 -> busy 10 cycles, hi/lo unchanged.
- mthi 0x12345678 then mult; mtlo attempted mid-RUN and `start` attempted mid-RUN -> both ignored, only product commits; `start`+`hi_we` same idle cycle -> hi from result only.
- Reset asserted on 3rd busy cycle of div with hi=lo=5 -> next cycle busy=0, hi=lo=0, no later commit.
- With `MULT_DIV_MADD_EN`: hi=0, lo=0xFFFFFFFF, multu acc=1 A=1 B=1 -> hi=1, lo=0; without macro same stimulus -> hi=0, lo=1.
